// File: rtl/game_flow_ctrl_if.sv
// Signal bundle between the game sequencer and its neighbours: IR receiver,
// snake engine, display mux and score display.
interface game_flow_ctrl_if;
    logic [31:0] ir_word;
    logic        ir_valid;
    logic        game_over;
    logic        food_eaten;
    logic        step;
    logic        game_clear;
    logic [1:0]  dir;
    logic [1:0]  screen_sel;
    logic [7:0]  score;
    logic [7:0]  high_score;
    logic [3:0]  level;

    modport master (
        output ir_word, ir_valid, game_over, food_eaten,
        input  step, game_clear, dir, screen_sel, score, high_score, level
    );

    modport slave (
        input  ir_word, ir_valid, game_over, food_eaten,
        output step, game_clear, dir, screen_sel, score, high_score, level
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Snake game sequencer: decodes NEC remote commands, runs the START/PLAY/PAUSE/OVER
// screen flow, paces the snake with step pulses and keeps BCD score, high score and level.
module game_flow_ctrl #(
    parameter logic [31:0] STEP_DIV  = 32'd12_500_000,
    parameter logic [31:0] STEP_DEC  = 32'd1_000_000,
    parameter logic [31:0] STEP_MIN  = 32'd4_000_000,
    parameter logic [31:0] OVER_HOLD = 32'd50_000_000,
    parameter logic [15:0] IR_ADDR   = 16'h20DF,
    parameter logic [7:0]  KEY_OK    = 8'h22,
    parameter logic [7:0]  KEY_PAUSE = 8'hA8,
    parameter logic [7:0]  KEY_UP    = 8'h02,
    parameter logic [7:0]  KEY_DOWN  = 8'h82,
    parameter logic [7:0]  KEY_LEFT  = 8'hE0,
    parameter logic [7:0]  KEY_RIGHT = 8'h60
) (
    input logic             CLOCK_50,
    input logic             reset,
    game_flow_ctrl_if.slave ctrl
);

    typedef enum logic [2:0] {
        ST_START,
        ST_CLEAR,
        ST_PLAY,
        ST_PAUSE,
        ST_OVER
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] stepCnt_q, stepCnt_d;
    logic [31:0] period_q, period_d;
    logic [31:0] hold_q, hold_d;
    logic [1:0]  dir_q, dir_d;
    logic [1:0]  pendDir_q, pendDir_d;
    logic [7:0]  score_q, score_d;
    logic [7:0]  highScore_q, highScore_d;
    logic [3:0]  level_q, level_d;
    logic [2:0]  foodCnt_q, foodCnt_d;
    logic [1:0]  screenSel_q, screenSel_d;

    logic        accepted;
    logic [7:0]  cmd;
    logic        keyOk, keyPause, keyDirValid, reversal, stepNow;
    logic [1:0]  keyDir;
    logic [31:0] levelDec, nextPeriod;

    // Saturating two-digit BCD increment; the score tops out at 99.
    function automatic logic [7:0] bcdInc(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign cmd      = ctrl.ir_word[15:8];
    assign accepted = ctrl.ir_valid && (ctrl.ir_word[31:16] == IR_ADDR)
                      && (ctrl.ir_word[15:8] == ~ctrl.ir_word[7:0]);
    assign keyOk    = accepted && (cmd == KEY_OK);
    assign keyPause = accepted && (cmd == KEY_PAUSE);
    assign stepNow  = (state_q == ST_PLAY) && (stepCnt_q == period_q - 32'd1);
    assign reversal = (keyDir[1] == dir_q[1]) && (keyDir != dir_q);

    always_comb begin
        keyDirValid = 1'b0;
        keyDir      = 2'd0;
        if (accepted) begin
            case (cmd)
                KEY_UP:    begin keyDirValid = 1'b1; keyDir = 2'd0; end
                KEY_DOWN:  begin keyDirValid = 1'b1; keyDir = 2'd1; end
                KEY_LEFT:  begin keyDirValid = 1'b1; keyDir = 2'd2; end
                KEY_RIGHT: begin keyDirValid = 1'b1; keyDir = 2'd3; end
                default:   begin keyDirValid = 1'b0; keyDir = 2'd0; end
            endcase
        end
    end

    // Period shrinks with level but never drops below the floor.
    always_comb begin
        levelDec = {28'd0, level_q} * STEP_DEC;
        if ((levelDec >= STEP_DIV) || ((STEP_DIV - levelDec) < STEP_MIN))
            nextPeriod = STEP_MIN;
        else
            nextPeriod = STEP_DIV - levelDec;
    end

    always_comb begin
        state_d     = state_q;
        stepCnt_d   = stepCnt_q;
        period_d    = period_q;
        hold_d      = hold_q;
        dir_d       = dir_q;
        pendDir_d   = pendDir_q;
        score_d     = score_q;
        highScore_d = highScore_q;
        level_d     = level_q;
        foodCnt_d   = foodCnt_q;

        case (state_q)
            ST_START: begin
                if (keyOk)
                    state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_d   = ST_PLAY;
                score_d   = 8'h00;
                level_d   = 4'd0;
                foodCnt_d = 3'd0;
                dir_d     = 2'd3;
                pendDir_d = 2'd3;
                stepCnt_d = 32'd0;
                period_d  = STEP_DIV;
            end
            ST_PLAY: begin
                if (stepNow) begin
                    stepCnt_d = 32'd0;
                    period_d  = nextPeriod;
                    dir_d     = pendDir_q;
                end else begin
                    stepCnt_d = stepCnt_q + 32'd1;
                end

                // A collision swallows any food or key arriving in the same cycle.
                if (ctrl.game_over) begin
                    state_d = ST_OVER;
                    hold_d  = OVER_HOLD;
                    if (score_q > highScore_q)
                        highScore_d = score_q;
                end else begin
                    if (ctrl.food_eaten) begin
                        score_d = bcdInc(score_q);
                        if (foodCnt_q == 3'd4) begin
                            foodCnt_d = 3'd0;
                            if (level_q != 4'd15)
                                level_d = level_q + 4'd1;
                        end else begin
                            foodCnt_d = foodCnt_q + 3'd1;
                        end
                    end
                    if (keyOk || keyPause)
                        state_d = ST_PAUSE;
                    else if (keyDirValid && !reversal)
                        pendDir_d = keyDir;
                end
            end
            ST_PAUSE: begin
                if (keyOk || keyPause)
                    state_d = ST_PLAY;
            end
            ST_OVER: begin
                if (hold_q != 32'd0)
                    hold_d = hold_q - 32'd1;
                else if (keyOk)
                    state_d = ST_START;
            end
            default: state_d = ST_START;
        endcase
    end

    always_comb begin
        screenSel_d = 2'd0;
        case (state_d)
            ST_START: screenSel_d = 2'd0;
            ST_CLEAR: screenSel_d = 2'd1;
            ST_PLAY:  screenSel_d = 2'd1;
            ST_PAUSE: screenSel_d = 2'd3;
            ST_OVER:  screenSel_d = 2'd2;
            default:  screenSel_d = 2'd0;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= ST_START;
            stepCnt_q   <= 32'd0;
            period_q    <= STEP_DIV;
            hold_q      <= 32'd0;
            dir_q       <= 2'd3;
            pendDir_q   <= 2'd3;
            score_q     <= 8'h00;
            highScore_q <= 8'h00;
            level_q     <= 4'd0;
            foodCnt_q   <= 3'd0;
            screenSel_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            stepCnt_q   <= stepCnt_d;
            period_q    <= period_d;
            hold_q      <= hold_d;
            dir_q       <= dir_d;
            pendDir_q   <= pendDir_d;
            score_q     <= score_d;
            highScore_q <= highScore_d;
            level_q     <= level_d;
            foodCnt_q   <= foodCnt_d;
            screenSel_q <= screenSel_d;
        end
    end

    assign ctrl.step       = stepNow;
    assign ctrl.game_clear = (state_q == ST_CLEAR);
    assign ctrl.dir        = dir_q;
    assign ctrl.screen_sel = screenSel_q;
    assign ctrl.score      = score_q;
    assign ctrl.high_score = highScore_q;
    assign ctrl.level      = level_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with small timing parameters so a full
// game (start, steering, pause, scoring, game over, reset) fits in a few hundred cycles.
module tb_game_flow_ctrl;

    localparam logic [7:0] OK    = 8'h22;
    localparam logic [7:0] PAUSE = 8'hA8;
    localparam logic [7:0] UP    = 8'h02;
    localparam logic [7:0] LEFT  = 8'hE0;

    logic CLOCK_50;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   stepCount = 0;
    int   gcCount = 0;
    int   lastStep = 0;
    int   lastGc = 0;

    game_flow_ctrl_if bus();

    game_flow_ctrl #(
        .STEP_DIV (32'd10),
        .STEP_DEC (32'd2),
        .STEP_MIN (32'd4),
        .OVER_HOLD(32'd8)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .ctrl    (bus.slave)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Pulse outputs are logged mid-cycle so intervals can be measured in whole cycles.
    always @(negedge CLOCK_50) begin
        if (bus.step) begin
            stepCount <= stepCount + 1;
            lastStep  <= cyc;
        end
        if (bus.game_clear) begin
            gcCount <= gcCount + 1;
            lastGc  <= cyc;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic logic [31:0] keyWord(input logic [7:0] c);
        return {16'h20DF, c, ~c};
    endfunction

    task automatic applyStimulus(input logic [31:0] word);
        bus.ir_word  = word;
        bus.ir_valid = 1'b1;
        tick();
        bus.ir_valid = 1'b0;
    endtask

    task automatic applyFood(input int n);
        repeat (n) begin
            bus.food_eaten = 1'b1;
            tick();
            bus.food_eaten = 1'b0;
        end
    endtask

    task automatic waitStep(input int budget);
        int start;
        int n;
        start = stepCount;
        n = 0;
        while (stepCount == start && n < budget) begin
            tick();
            n++;
        end
        if (stepCount == start)
            checkOutput("stepTimeout", 32'd0, 32'd1);
    endtask

    task automatic endGame(input logic withFood);
        bus.game_over  = 1'b1;
        bus.food_eaten = withFood;
        tick();
        bus.game_over  = 1'b0;
        bus.food_eaten = 1'b0;
    endtask

    initial begin
        int s0;
        int g0;
        int r;
        reset          = 1'b1;
        bus.ir_word    = 32'd0;
        bus.ir_valid   = 1'b0;
        bus.game_over  = 1'b0;
        bus.food_eaten = 1'b0;
        repeat (2) tick();
        reset = 1'b0;

        checkOutput("rstScreen", 32'(bus.screen_sel), 32'd0);
        checkOutput("rstDir", 32'(bus.dir), 32'd3);
        checkOutput("rstScore", 32'(bus.score), 32'h00);
        checkOutput("rstHigh", 32'(bus.high_score), 32'h00);
        checkOutput("rstLevel", 32'(bus.level), 32'd0);

        // Malformed words must leave the start screen alone.
        applyStimulus(32'h20DF22DC);
        applyStimulus(32'h10EF22DD);
        tick();
        checkOutput("badWordScreen", 32'(bus.screen_sel), 32'd0);
        checkOutput("badWordClear", 32'(gcCount), 32'd0);

        // Game 1: start, steering, pause, game over at 07.
        applyStimulus(keyWord(OK));
        checkOutput("clearPulse", 32'(bus.game_clear), 32'd1);
        checkOutput("clearScreen", 32'(bus.screen_sel), 32'd1);
        waitStep(30);
        checkOutput("firstStepGap", 32'(lastStep - lastGc), 32'd10);
        checkOutput("clearOnce", 32'(gcCount), 32'd1);
        s0 = lastStep;
        waitStep(30);
        checkOutput("stepPeriod", 32'(lastStep - s0), 32'd10);

        applyStimulus(keyWord(LEFT));
        waitStep(30);
        checkOutput("reversalDropped", 32'(bus.dir), 32'd3);
        applyStimulus(keyWord(UP));
        checkOutput("dirBeforeStep", 32'(bus.dir), 32'd3);
        waitStep(30);
        checkOutput("dirAfterStep", 32'(bus.dir), 32'd0);

        repeat (2) tick();
        applyStimulus(keyWord(PAUSE));
        checkOutput("pauseScreen", 32'(bus.screen_sel), 32'd3);
        s0 = stepCount;
        applyStimulus(keyWord(LEFT));
        applyFood(1);
        repeat (48) tick();
        checkOutput("pauseNoStep", 32'(stepCount), 32'(s0));
        checkOutput("pauseNoFood", 32'(bus.score), 32'h00);
        r = cyc;
        applyStimulus(keyWord(OK));
        checkOutput("resumeScreen", 32'(bus.screen_sel), 32'd1);
        waitStep(30);
        checkOutput("resumeGap", 32'(lastStep - r), 32'd7);
        checkOutput("pauseNoDir", 32'(bus.dir), 32'd0);

        applyFood(7);
        checkOutput("score07", 32'(bus.score), 32'h07);
        checkOutput("level1", 32'(bus.level), 32'd1);
        endGame(1'b1);
        checkOutput("overScreen", 32'(bus.screen_sel), 32'd2);
        checkOutput("overScore", 32'(bus.score), 32'h07);
        checkOutput("overHigh", 32'(bus.high_score), 32'h07);
        applyStimulus(keyWord(OK));
        repeat (3) tick();
        checkOutput("holdIgnoresOk", 32'(bus.screen_sel), 32'd2);
        repeat (8) tick();
        applyStimulus(keyWord(OK));
        checkOutput("backToStart", 32'(bus.screen_sel), 32'd0);

        // Game 2: lower score must not displace the high score.
        applyStimulus(keyWord(OK));
        checkOutput("clearPulse2", 32'(bus.game_clear), 32'd1);
        tick();
        checkOutput("newScore", 32'(bus.score), 32'h00);
        checkOutput("newDir", 32'(bus.dir), 32'd3);
        applyFood(5);
        checkOutput("score05", 32'(bus.score), 32'h05);
        endGame(1'b0);
        checkOutput("keepHigh", 32'(bus.high_score), 32'h07);
        checkOutput("keepScore", 32'(bus.score), 32'h05);
        repeat (10) tick();
        applyStimulus(keyWord(OK));
        checkOutput("backToStart2", 32'(bus.screen_sel), 32'd0);

        // Game 3: reset with the step counter at 6.
        applyStimulus(keyWord(OK));
        waitStep(30);
        repeat (6) tick();
        s0 = stepCount;
        g0 = gcCount;
        reset = 1'b1;
        tick();
        checkOutput("midRstStep", 32'(bus.step), 32'd0);
        checkOutput("midRstClear", 32'(bus.game_clear), 32'd0);
        checkOutput("midRstScreen", 32'(bus.screen_sel), 32'd0);
        checkOutput("midRstHigh", 32'(bus.high_score), 32'h00);
        checkOutput("midRstDir", 32'(bus.dir), 32'd3);
        reset = 1'b0;
        repeat (20) tick();
        checkOutput("midRstNoStep", 32'(stepCount), 32'(s0));
        checkOutput("midRstNoClear", 32'(gcCount), 32'(g0));

        // Game 4: speed levels and saturation.
        applyStimulus(keyWord(OK));
        tick();
        applyFood(12);
        checkOutput("score12", 32'(bus.score), 32'h12);
        checkOutput("level2", 32'(bus.level), 32'd2);
        waitStep(30);
        s0 = lastStep;
        waitStep(30);
        checkOutput("period6", 32'(lastStep - s0), 32'd6);
        applyFood(87);
        checkOutput("score99", 32'(bus.score), 32'h99);
        applyFood(1);
        checkOutput("scoreSat", 32'(bus.score), 32'h99);
        checkOutput("levelSat", 32'(bus.level), 32'd15);
        waitStep(30);
        s0 = lastStep;
        waitStep(30);
        checkOutput("periodMin", 32'(lastStep - s0), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
